clock_divider_multi: RTL and testbench

Parametrised multi-channel clock divider generating NUM_CH independent 50%-duty divided clocks, plus a one-cycle rising-edge tick per channel, from the board clock. Each channel's half-period is reprogrammed at run time through a valid/ready config port. A new value takes effect only at the channel's next terminal count, so outputs never glitch. It sits next to the board clock and feeds slow-clock and tick consumers such as counters, display scanners and debouncers.

---
 rtl/clock_divider_multi.sv | 107 ++++++++++
 tb/tb_clock_divider_multi.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent 50%-duty clock dividers with
// rising-edge ticks and a glitch-free, run-time half-period config port.
//
// Ports:
//   clk_50MHz    board clock, all state on its rising edge
//   reset        asynchronous, active-low
//   en           per-channel run enable
//   sync_restart one-cycle pulse, realigns every channel to phase 0
//   cfg_valid    config request (hold cfg_ch/cfg_half until accepted)
//   cfg_ready    high when a config write can be accepted
//   cfg_ch       target channel (out-of-range writes are dropped)
//   cfg_half     new half-period in clk_50MHz cycles (0 acts as 1)
//   clk_out      divided clocks
//   tick         one-cycle pulse on each clk_out rising transition
module clock_divider_multi #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 25_000_000,
  parameter int          CH_W         =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] HALF_RST =
    CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic xfer;

  assign xfer = cfg_valid & cfg_ready;

  // One dead cycle after every accepted write.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      cfg_ready <= 1'b1;
    end else begin
      cfg_ready <= ~xfer;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_val_q;
    logic [CNT_W-1:0] h_m1;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             hit;
    logic             term;
    logic             hold;

    assign hit  = xfer && (32'(cfg_ch) == i);
    // A half-period of 0 behaves as 1: terminal count is 0.
    assign h_m1 = (half_q == '0) ? '0 : half_q - ONE;
    assign term = (cnt_q == h_m1);
    assign hold = sync_restart | ~en[i];

    always_ff @(posedge clk_50MHz or negedge reset) begin
      if (!reset) begin
        cnt_q      <= '0;
        half_q     <= HALF_RST;
        pend_val_q <= '0;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        if (hold) begin
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (term) begin
          cnt_q  <= '0;
          clk_q  <= ~clk_q;
          tick_q <= ~clk_q;
        end else begin
          cnt_q  <= cnt_q + ONE;
          tick_q <= 1'b0;
        end
        // Pending value only swaps in at a phase boundary.
        if ((hold || term) && pend_q) begin
          half_q <= pend_val_q;
          pend_q <= 1'b0;
        end
        // Written last: a write on the apply edge stays pending.
        if (hit) begin
          pend_val_q <= cfg_half;
          pend_q     <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed checks of clock_divider_multi
// with hand-computed edge-by-edge expectations.
module tb_clock_divider_multi;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] en = '0;
  logic       sync_restart = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_half = '0;
  logic [4:0] clk_out;
  logic [4:0] tick;

  int nvec = 0;
  int nerr = 0;
  int k = 0;

  clock_divider_multi #(
    .NUM_CH(5),
    .CNT_W(8),
    .DEFAULT_HALF(3)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .en(en),
    .sync_restart(sync_restart),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
    k++;
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  task automatic rst_seq(input logic [4:0] e);
    reset = 1'b0;
    cfg_valid = 1'b0;
    sync_restart = 1'b0;
    en = e;
    @(posedge clk_50MHz);
    @(posedge clk_50MHz);
    #1;
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    // T1: reset state, then default half=3 on all channels
    en = 5'h1f;
    @(posedge clk_50MHz);
    @(posedge clk_50MHz);
    #1;
    check("t1_rst_clk", clk_out, 5'h00);
    check("t1_rst_tick", tick, 5'h00);
    check("t1_rst_rdy", cfg_ready, 1'b1);
    reset = 1'b1;
    k = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("t1_clk_%0d", n), clk_out,
            ((n / 3) % 2 == 1) ? 5'h1f : 5'h00);
      check($sformatf("t1_tick_%0d", n), tick,
            (n % 6 == 3) ? 5'h1f : 5'h00);
    end

    // T2: ch1 reprogrammed to 5 mid-period
    rst_seq(5'h1f);
    step();
    cfg_valid = 1'b1;
    cfg_ch = 3'd1;
    cfg_half = 8'd5;
    step();
    cfg_valid = 1'b0;
    check("t2_rdy_lo", cfg_ready, 1'b0);
    step();
    check("t2_rdy_hi", cfg_ready, 1'b1);
    check("t2_c1_rise3", clk_out[1], 1'b1);
    run_to(7);
    check("t2_c1_hi7", clk_out[1], 1'b1);
    check("t2_c0_lo7", clk_out[0], 1'b0);
    run_to(8);
    check("t2_c1_fall8", clk_out[1], 1'b0);
    run_to(12);
    check("t2_c1_lo12", clk_out[1], 1'b0);
    run_to(13);
    check("t2_c1_rise13", clk_out[1], 1'b1);
    check("t2_t1_13", tick[1], 1'b1);
    run_to(17);
    check("t2_c1_hi17", clk_out[1], 1'b1);
    run_to(18);
    check("t2_c1_fall18", clk_out[1], 1'b0);

    // T3: half=0 on ch0, en toggling on ch0 and ch2
    rst_seq(5'b11110);
    cfg_valid = 1'b1;
    cfg_ch = 3'd0;
    cfg_half = 8'd0;
    step();
    cfg_valid = 1'b0;
    step();
    check("t3_c0_off2", clk_out[0], 1'b0);
    en[0] = 1'b1;
    step();
    check("t3_c0_3", clk_out[0], 1'b1);
    check("t3_t0_3", tick[0], 1'b1);
    check("t3_c2_3", clk_out[2], 1'b1);
    step();
    check("t3_c0_4", clk_out[0], 1'b0);
    check("t3_t0_4", tick[0], 1'b0);
    en[2] = 1'b0;
    step();
    check("t3_c0_5", clk_out[0], 1'b1);
    check("t3_c2_off5", clk_out[2], 1'b0);
    en[2] = 1'b1;
    en[0] = 1'b0;
    step();
    check("t3_c2_6", clk_out[2], 1'b0);
    step();
    check("t3_c0_off7", clk_out[0], 1'b0);
    check("t3_c2_7", clk_out[2], 1'b0);
    en[0] = 1'b1;
    step();
    check("t3_c0_8", clk_out[0], 1'b1);
    check("t3_t0_8", tick[0], 1'b1);
    check("t3_c2_8", clk_out[2], 1'b1);
    check("t3_t2_8", tick[2], 1'b1);

    // T4: sync_restart realigns half=4 (ch1, ch2) and half=7 (ch3)
    rst_seq(5'b00000);
    cfg_valid = 1'b1;
    cfg_ch = 3'd1;
    cfg_half = 8'd4;
    step();
    cfg_valid = 1'b0;
    step();
    cfg_valid = 1'b1;
    cfg_ch = 3'd2;
    step();
    cfg_valid = 1'b0;
    step();
    cfg_valid = 1'b1;
    cfg_ch = 3'd3;
    cfg_half = 8'd7;
    step();
    cfg_valid = 1'b0;
    step();
    en = 5'b01010;
    run_to(8);
    en = 5'b01110;
    run_to(10);
    check("t4_oop10", clk_out[2:1], 2'b01);
    run_to(11);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("t4_sr_clk", clk_out, 5'h00);
    check("t4_sr_tick", tick, 5'h00);
    run_to(15);
    check("t4_clk15", clk_out, 5'h00);
    step();
    check("t4_clk16", clk_out, 5'b00110);
    check("t4_tick16", tick, 5'b00110);
    run_to(18);
    check("t4_clk18", clk_out, 5'b00110);
    step();
    check("t4_clk19", clk_out, 5'b01110);
    check("t4_tick19", tick, 5'b01000);
    step();
    check("t4_clk20", clk_out, 5'b01000);

    // T5: write on ch2 terminal count, then out-of-range write
    rst_seq(5'h1f);
    run_to(2);
    cfg_valid = 1'b1;
    cfg_ch = 3'd2;
    cfg_half = 8'd5;
    step();
    check("t5_rdy3", cfg_ready, 1'b0);
    check("t5_c2_3", clk_out[2], 1'b1);
    cfg_ch = 3'd5;
    cfg_half = 8'd1;
    step();
    check("t5_rdy4", cfg_ready, 1'b1);
    step();
    check("t5_rdy5", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    step();
    check("t5_rdy6", cfg_ready, 1'b1);
    check("t5_c2_6", clk_out[2], 1'b0);
    run_to(10);
    check("t5_c2_10", clk_out[2], 1'b0);
    step();
    check("t5_c2_11", clk_out[2], 1'b1);
    check("t5_t2_11", tick[2], 1'b1);
    run_to(12);
    check("t5_clk12", clk_out, 5'b00100);
    run_to(15);
    check("t5_clk15", clk_out, 5'h1f);
    check("t5_tick15", tick, 5'b11011);
    step();
    check("t5_clk16", clk_out, 5'b11011);

    // T6: async reset mid-period discards a pending write
    rst_seq(5'h1f);
    run_to(2);
    cfg_valid = 1'b1;
    cfg_ch = 3'd0;
    cfg_half = 8'd6;
    step();
    cfg_valid = 1'b0;
    check("t6_pre_tick", tick[0], 1'b1);
    check("t6_pre_rdy", cfg_ready, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_ar_clk", clk_out, 5'h00);
    check("t6_ar_tick", tick, 5'h00);
    check("t6_ar_rdy", cfg_ready, 1'b1);
    rst_seq(5'h1f);
    run_to(6);
    check("t6_c0_6", clk_out[0], 1'b0);
    run_to(9);
    check("t6_c0_9", clk_out[0], 1'b1);
    check("t6_t0_9", tick[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
